// File: rtl/lc3b_wait_mem.sv
// ---------------------------------------------------------------------------
// lc3b_wait_mem
//   Word-organised memory model with a programmable number of wait states,
//   serving the LC-3b multicycle memory port. One mem_read/mem_write request
//   is accepted at a time. Completion is signalled by a one-cycle mem_resp
//   pulse LATENCY cycles after the edge that sampled the request.
//
//   Parameters
//     ADDR_WIDTH   byte-address width (bit 0 ignored)
//     DEPTH_WORDS  number of 16-bit words; word index = mem_address[ADDR_WIDTH-1:1]
//     LATENCY      request-sampling edge to mem_resp cycle, >= 1
//
//   Ports
//     clk              rising-edge clock
//     rst_n            asynchronous active-low reset (array contents kept)
//     mem_read         read request, held until mem_resp
//     mem_write        write request, held until mem_resp
//     mem_byte_enable  write lanes: [0] -> data[7:0], [1] -> data[15:8]
//     mem_address      byte address
//     mem_wdata        write data
//     mem_rdata        registered read data, held until the next read completes
//     mem_resp         one-cycle completion pulse
//     mem_err          error flag aligned with mem_resp
//
//   Optional feature macro: LC3B_MEM_ERR_EN
//     defined   -> mem_err=1 in the response cycle of an out-of-range access
//                  or a simultaneous read+write request
//     undefined -> mem_err tied low, no error logic
// ---------------------------------------------------------------------------
module lc3b_wait_mem #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            mem_byte_enable,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [15:0]           mem_wdata,
    output logic [15:0]           mem_rdata,
    output logic                  mem_resp,
    output logic                  mem_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] WORD_LIMIT = ADDR_WIDTH'(DEPTH_WORDS);

    logic [15:0]   mem [DEPTH_WORDS];

    logic [1:0]    state;
    logic [CW-1:0] cnt;

    logic          lat_read;
    logic          lat_write;
    logic [1:0]    lat_be;
    logic [15:0]   lat_wdata;
    logic [IW-1:0] lat_idx;
    logic          lat_in_range;

    logic          req;
    logic          in_range_now;
    logic [IW-1:0] idx_now;
    logic          enter_resp;
    logic          rd_go;
    logic [IW-1:0] rd_idx;
    logic          rd_ok;
    logic [15:0]   rd_data;

    // Bit 0 selects a byte within the word and plays no part in word access.
    logic          unused_addr_bit;
    assign unused_addr_bit = mem_address[0];

    assign req          = mem_read | mem_write;
    assign in_range_now = {1'b0, mem_address[ADDR_WIDTH-1:1]} < WORD_LIMIT;
    assign idx_now      = mem_address[IW:1];

    // With LATENCY==1 the edge that samples the request is also the edge that
    // enters RESP, so the read must be sourced from the live inputs rather
    // than the latched copy.
    always_comb begin
        enter_resp = 1'b0;
        rd_go      = 1'b0;
        rd_idx     = lat_idx;
        rd_ok      = lat_in_range;
        if (state == S_IDLE && req && LATENCY == 1) begin
            enter_resp = 1'b1;
            rd_go      = mem_read;
            rd_idx     = idx_now;
            rd_ok      = in_range_now;
        end else if (state == S_WAIT && cnt == CW'(1)) begin
            enter_resp = 1'b1;
            rd_go      = lat_read;
        end
    end

    assign rd_data = rd_ok ? mem[rd_idx] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            mem_resp     <= 1'b0;
            mem_rdata    <= '0;
            lat_read     <= 1'b0;
            lat_write    <= 1'b0;
            lat_be       <= '0;
            lat_wdata    <= '0;
            lat_idx      <= '0;
            lat_in_range <= 1'b0;
        end else begin
            mem_resp <= enter_resp;
            if (enter_resp && rd_go) begin
                mem_rdata <= rd_data;
            end
            case (state)
                S_IDLE: begin
                    if (req) begin
                        // read+write together is served as a read only
                        lat_read     <= mem_read;
                        lat_write    <= mem_write & ~mem_read;
                        lat_be       <= mem_byte_enable;
                        lat_wdata    <= mem_wdata;
                        lat_idx      <= idx_now;
                        lat_in_range <= in_range_now;
                        cnt          <= CW'(LATENCY - 1);
                        state        <= (LATENCY == 1) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Array is never reset; writes commit on the edge leaving RESP, so a reset
    // during WAIT aborts the write cleanly.
    always_ff @(posedge clk) begin
        if (state == S_RESP && lat_write && lat_in_range) begin
            if (lat_be[0]) mem[lat_idx][7:0]  <= lat_wdata[7:0];
            if (lat_be[1]) mem[lat_idx][15:8] <= lat_wdata[15:8];
        end
    end

`ifdef LC3B_MEM_ERR_EN
    logic lat_err;
    logic err_now;
    logic err_src;
    logic err_q;

    assign err_now = (mem_read & mem_write) | ~in_range_now;
    assign err_src = (state == S_IDLE) ? err_now : lat_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_err <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= enter_resp & err_src;
            if (state == S_IDLE && req) begin
                lat_err <= err_now;
            end
        end
    end

    assign mem_err = err_q;
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_lc3b_wait_mem.sv
module tb_lc3b_wait_mem;

`ifdef LC3B_MEM_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    typedef struct {
        int          id;
        int          tag;
        logic [15:0] rdata;
        bit          err;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        rd    [3];
    logic        wr    [3];
    logic [1:0]  be    [3];
    logic [15:0] addr  [3];
    logic [15:0] wdata [3];
    logic [15:0] rdata [3];
    logic        resp  [3];
    logic        err   [3];

    int   cyc;
    int   n_cmp;
    int   n_bad;
    int   tag_n;
    exp_t sbq[$];
    exp_t mon_e;

    function automatic int lat_of(input int id);
        return (id == 0) ? 3 : ((id == 1) ? 1 : 5);
    endfunction

    // DUT 0: LATENCY=3, DUT 1: LATENCY=1, DUT 2: LATENCY=5
    for (genvar g = 0; g < 3; g++) begin : g_dut
        lc3b_wait_mem #(
            .ADDR_WIDTH (16),
            .DEPTH_WORDS(256),
            .LATENCY    ((g == 0) ? 3 : ((g == 1) ? 1 : 5))
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .mem_read       (rd[g]),
            .mem_write      (wr[g]),
            .mem_byte_enable(be[g]),
            .mem_address    (addr[g]),
            .mem_wdata      (wdata[g]),
            .mem_rdata      (rdata[g]),
            .mem_resp       (resp[g]),
            .mem_err        (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: every mem_resp pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (resp[i] === 1'b1) begin
                if (sbq.size() == 0 || sbq[0].id != i) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp dut%0d: got resp=1 at cycle %0d want no resp", i, cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    check($sformatf("rdata txn%0d", mon_e.tag), 32'(rdata[i]), 32'(mon_e.rdata));
                    check($sformatf("err txn%0d", mon_e.tag), 32'(err[i]), 32'(mon_e.err));
                    check($sformatf("resp_cycle txn%0d", mon_e.tag), 32'(cyc), 32'(mon_e.cyc));
                end
            end
        end
    end

    task automatic txn(input int id, input bit r, input bit w, input logic [1:0] m,
                       input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] exp_rd, input bit exp_err, input bit chg);
        exp_t e;
        bit   done;
        @(negedge clk);
        rd[id]    = r;
        wr[id]    = w;
        be[id]    = m;
        addr[id]  = a;
        wdata[id] = d;
        e.id    = id;
        e.tag   = tag_n;
        e.rdata = exp_rd;
        e.err   = ERR_ON & exp_err;
        e.cyc   = cyc + lat_of(id);
        tag_n++;
        sbq.push_back(e);
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            #1;
            if (chg && k == 0) addr[id] = 16'h0020;
            if (sbq.size() == 0) done = 1'b1;
        end
        rd[id] = 1'b0;
        wr[id] = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout txn%0d: got no resp within 20 cycles want resp", e.tag);
            sbq.delete();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        tag_n = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; be[i] = '0; addr[i] = '0; wdata[i] = '0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_rdata dut%0d", i), 32'(rdata[i]), 32'h0);
            check($sformatf("reset_resp dut%0d", i), 32'(resp[i]), 32'h0);
            check($sformatf("reset_err dut%0d", i), 32'(err[i]), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        //  id r  w  mask   addr      wdata     exp_rdata err chg
        txn(0, 0, 1, 2'b11, 16'h0010, 16'hBEEF, 16'h0000, 0, 0);
        txn(0, 1, 0, 2'b00, 16'h0010, 16'h0000, 16'hBEEF, 0, 0);
        txn(0, 0, 1, 2'b11, 16'h0020, 16'h1234, 16'hBEEF, 0, 0);
        txn(0, 0, 1, 2'b01, 16'h0020, 16'hABCD, 16'hBEEF, 0, 0);
        txn(0, 1, 0, 2'b00, 16'h0020, 16'h0000, 16'h12CD, 0, 0);
        txn(0, 0, 1, 2'b10, 16'h0020, 16'hABCD, 16'h12CD, 0, 0);
        txn(0, 1, 0, 2'b00, 16'h0020, 16'h0000, 16'hABCD, 0, 0);
        txn(0, 0, 1, 2'b00, 16'h0020, 16'h0000, 16'hABCD, 0, 0);
        txn(0, 1, 0, 2'b00, 16'h0020, 16'h0000, 16'hABCD, 0, 0);
        // address switched to 0x0020 during WAIT: latched 0x0010 is served
        txn(0, 1, 0, 2'b00, 16'h0010, 16'h0000, 16'hBEEF, 0, 1);
        // read+write together: read served, write of 0x0000 dropped
        txn(0, 1, 1, 2'b11, 16'h0010, 16'h0000, 16'hBEEF, 1, 0);
        txn(0, 1, 0, 2'b00, 16'h0010, 16'h0000, 16'hBEEF, 0, 0);
        // out-of-range write must not alias onto word 0
        txn(0, 0, 1, 2'b11, 16'h0000, 16'h7777, 16'hBEEF, 0, 0);
        txn(0, 0, 1, 2'b11, 16'h0400, 16'hFFFF, 16'hBEEF, 1, 0);
        txn(0, 1, 0, 2'b00, 16'h0000, 16'h0000, 16'h7777, 0, 0);
        txn(0, 1, 0, 2'b00, 16'h0400, 16'h0000, 16'h0000, 1, 0);

        // reset during WAIT of a write: aborted, no response
        @(negedge clk);
        wr[0] = 1'b1; be[0] = 2'b11; addr[0] = 16'h0010; wdata[0] = 16'h5555;
        @(negedge clk);
        rst_n = 1'b0;
        wr[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("no_resp_after_reset c%0d", k), 32'(resp[0]), 32'h0);
        end
        check("rdata_after_midop_reset", 32'(rdata[0]), 32'h0);
        txn(0, 1, 0, 2'b00, 16'h0010, 16'h0000, 16'hBEEF, 0, 0);

        // latency sweep
        txn(1, 0, 1, 2'b11, 16'h0008, 16'h0123, 16'h0000, 0, 0);
        txn(1, 1, 0, 2'b00, 16'h0008, 16'h0000, 16'h0123, 0, 0);
        txn(2, 0, 1, 2'b11, 16'h0008, 16'h4567, 16'h0000, 0, 0);
        txn(2, 1, 0, 2'b00, 16'h0008, 16'h0000, 16'h4567, 0, 0);

        repeat (8) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
